temporal_encoder: RTL and testbench

Upstream stage of the pulse-width temporal primitives (min/max/inhibit). Accepts a vector of binary values over a valid/ready handshake, buffers one word, and replays it in the next gamma cycle as one spike per channel. Each spike's rising edge lands at phase = value. The block owns the gamma-phase counter and emits a gamma-start strobe that downstream primitives take as their gamma reset.

---
 rtl/temporal_pkg.sv | 16 +
 rtl/gamma_counter.sv | 37 +++
 rtl/temporal_encoder.sv | 94 +++++++++
 tb/tb_temporal_encoder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/temporal_pkg.sv
// Shared gamma-cycle timing constants and spike-time types for the temporal primitives
// (encoder, min/max/inhibit, decoder).
package temporal_pkg;

  localparam int GAMMA_CYCLE_WIDTH = 16;
  localparam int PULSE_WIDTH       = 8;
  localparam int VAL_W             = $clog2(GAMMA_CYCLE_WIDTH);

  typedef logic [VAL_W-1:0] spk_time_t;

  typedef struct packed {
    spk_time_t val;
    logic      null_f;
  } chan_t;

endpackage

// File: rtl/gamma_counter.sv
// Gamma-phase counter with a registered phase-0 strobe.
// Also exposes the next phase and the wrap edge so consumers can stay cycle-aligned.
module gamma_counter
  import temporal_pkg::*;
#(
  parameter int G = GAMMA_CYCLE_WIDTH,
  parameter int W = $clog2(G)
) (
  input  logic         aclk,
  input  logic         grst,
  output logic [W-1:0] phase,
  output logic [W-1:0] phase_nxt,
  output logic         gstart,
  output logic         wrap
);

  logic running;

  // The first edge out of reset holds phase at 0 so that cycle raises gstart.
  always_comb begin
    phase_nxt = running ? phase + W'(1) : '0;
    wrap      = running && (phase == W'(G - 1));
  end

  always_ff @(posedge aclk) begin
    if (grst) begin
      phase   <= '0;
      gstart  <= 1'b0;
      running <= 1'b0;
    end else begin
      phase   <= phase_nxt;
      gstart  <= (phase_nxt == '0);
      running <= 1'b1;
    end
  end

endmodule

// File: rtl/temporal_encoder.sv
// Buffers one input word and replays it in the following gamma cycle as one spike per channel.
// Define ENC_FALLING_EN for falling-edge encoding (spk idles high, pulses low).
module temporal_encoder
  import temporal_pkg::*;
#(
  parameter int NUM_CH = 2
) (
  input  logic                    aclk,
  input  logic                    grst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_CH*VAL_W-1:0] in_val,
  input  logic [NUM_CH-1:0]       in_null,
  output logic                    gstart,
  output spk_time_t               gphase,
  output logic [NUM_CH-1:0]       spk,
  output logic                    busy
);

`ifdef ENC_FALLING_EN
  localparam logic SPK_IDLE = 1'b1;
`else
  localparam logic SPK_IDLE = 1'b0;
`endif

  spk_time_t                phase_nxt;
  logic                     wrap;
  logic                     accept;
  logic                     pend_vld;
  logic                     act_vld;
  logic                     act_vld_nxt;
  chan_t [NUM_CH-1:0]       in_word;
  chan_t [NUM_CH-1:0]       pend_q;
  chan_t [NUM_CH-1:0]       act_q;
  chan_t [NUM_CH-1:0]       act_nxt;
  logic  [NUM_CH-1:0]       hit;
  logic  [NUM_CH-1:0]       spk_nxt;

  gamma_counter #(
    .G (GAMMA_CYCLE_WIDTH),
    .W (VAL_W)
  ) u_gamma (
    .aclk      (aclk),
    .grst      (grst),
    .phase     (gphase),
    .phase_nxt (phase_nxt),
    .gstart    (gstart),
    .wrap      (wrap)
  );

  assign in_ready = !pend_vld && !grst;
  assign accept   = in_valid && in_ready;
  assign busy     = act_vld;

  // spk is registered, so the window is evaluated against next-cycle phase and slot contents.
  always_comb begin
    in_word     = '0;
    hit         = '0;
    act_vld_nxt = wrap ? pend_vld : act_vld;
    act_nxt     = wrap ? pend_q : act_q;
    for (int i = 0; i < NUM_CH; i++) begin
      in_word[i].val    = in_val[i*VAL_W +: VAL_W];
      in_word[i].null_f = in_null[i];
      hit[i] = act_vld_nxt && !act_nxt[i].null_f
               && (phase_nxt >= act_nxt[i].val)
               && (32'(phase_nxt) < 32'(act_nxt[i].val) + 32'(PULSE_WIDTH));
    end
    spk_nxt = hit ^ {NUM_CH{SPK_IDLE}};
  end

  // A word accepted on the wrap edge lands in pending; it never bypasses into active.
  always_ff @(posedge aclk) begin
    if (grst) begin
      pend_vld <= 1'b0;
      act_vld  <= 1'b0;
      pend_q   <= '0;
      act_q    <= '0;
      spk      <= {NUM_CH{SPK_IDLE}};
    end else begin
      if (wrap) begin
        act_q   <= pend_q;
        act_vld <= pend_vld;
      end
      if (accept) begin
        pend_q   <= in_word;
        pend_vld <= 1'b1;
      end else if (wrap) begin
        pend_vld <= 1'b0;
      end
      spk <= spk_nxt;
    end
  end

endmodule

// File: tb/tb_temporal_encoder.sv
// Directed self-checking bench for temporal_encoder (NUM_CH=2, G=16, P=8).
// Honours ENC_FALLING_EN the same way as the design.
module tb_temporal_encoder;

  localparam int G = 16;
  localparam int P = 8;

`ifdef ENC_FALLING_EN
  localparam logic [1:0] IDLE = 2'b11;
`else
  localparam logic [1:0] IDLE = 2'b00;
`endif

  logic       aclk = 1'b0;
  logic       grst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_val = '0;
  logic [1:0] in_null = '0;
  logic       gstart;
  logic [3:0] gphase;
  logic [1:0] spk;
  logic       busy;

  int errors = 0;
  int checks = 0;

  temporal_encoder #(.NUM_CH(2)) dut (
    .aclk     (aclk),
    .grst     (grst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_val   (in_val),
    .in_null  (in_null),
    .gstart   (gstart),
    .gphase   (gphase),
    .spk      (spk),
    .busy     (busy)
  );

  always #5 aclk = ~aclk;

  // Reference pulse shape: high on [v, v+P) within one gamma cycle, never wrapping.
  function automatic logic [1:0] exp_spk(input int v0, input int v1, input logic [1:0] nul,
                                         input logic act, input int ph);
    logic [1:0] r;
    int v [2];
    v[0] = v0;
    v[1] = v1;
    for (int i = 0; i < 2; i++)
      r[i] = act && !nul[i] && (ph >= v[i]) && (ph < v[i] + P) && (ph < G);
    return r ^ IDLE;
  endfunction

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic wait_phase(input int p);
    for (int n = 0; n < 40 && gphase !== 4'(p); n++) step();
    checks++;
    if (gphase !== 4'(p)) begin
      errors++;
      $display("[TB] FAIL wait_phase: gphase=%0d required %0d", gphase, p);
    end
  endtask

  task automatic test_reset();
    grst = 1'b1;
    repeat (3) step();
    checks += 4;
    if (spk !== IDLE) begin errors++; $display("[TB] FAIL rst_spk: got %b want %b", spk, IDLE); end
    if (gstart !== 1'b0) begin errors++; $display("[TB] FAIL rst_gstart: got %b want 0", gstart); end
    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_ready: got %b want 0", in_ready); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %b want 0", busy); end
    grst = 1'b0;
    step();
    for (int k = 0; k < 34; k++) begin
      checks += 2;
      if (gphase !== 4'(k % G)) begin
        errors++; $display("[TB] FAIL gphase_seq: k=%0d got %0d want %0d", k, gphase, k % G);
      end
      if (gstart !== (k % G == 0)) begin
        errors++; $display("[TB] FAIL gstart_seq: k=%0d got %b want %b", k, gstart, (k % G == 0));
      end
      step();
    end
  endtask

  task automatic test_replay_and_hold();
    wait_phase(5);
    in_valid = 1'b1;
    in_val   = {4'd4, 4'd2};
    in_null  = 2'b00;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL ready_empty: got %b want 1", in_ready); end
    step();
    in_val = {4'd6, 4'd6};
    for (int ph = 6; ph < G; ph++) begin
      checks += 2;
      if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL ready_full: ph=%0d got %b want 0", ph, in_ready); end
      if (spk !== IDLE) begin errors++; $display("[TB] FAIL pre_replay_spk: ph=%0d got %b want %b", ph, spk, IDLE); end
      step();
    end
    checks += 2;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL ready_after_wrap: got %b want 1", in_ready); end
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL busy_replay1: got %b want 1", busy); end
    for (int ph = 0; ph < G; ph++) begin
      checks++;
      if (spk !== exp_spk(2, 4, 2'b00, 1'b1, ph)) begin
        errors++; $display("[TB] FAIL replay1: ph=%0d got %b want %b", ph, spk, exp_spk(2, 4, 2'b00, 1'b1, ph));
      end
      step();
      if (ph == 0) in_valid = 1'b0;
    end
    for (int ph = 0; ph < G; ph++) begin
      checks += 2;
      if (busy !== 1'b1) begin errors++; $display("[TB] FAIL busy_replay2: ph=%0d got %b want 1", ph, busy); end
      if (spk !== exp_spk(6, 6, 2'b00, 1'b1, ph)) begin
        errors++; $display("[TB] FAIL replay_held: ph=%0d got %b want %b", ph, spk, exp_spk(6, 6, 2'b00, 1'b1, ph));
      end
      step();
    end
  endtask

  task automatic test_truncate_null();
    in_valid = 1'b1;
    in_val   = {4'd0, 4'd12};
    in_null  = 2'b00;
    step();
    in_valid = 1'b0;
    wait_phase(0);
    for (int ph = 0; ph < G; ph++) begin
      checks++;
      if (spk !== exp_spk(12, 0, 2'b00, 1'b1, ph)) begin
        errors++; $display("[TB] FAIL truncate: ph=%0d got %b want %b", ph, spk, exp_spk(12, 0, 2'b00, 1'b1, ph));
      end
      if (ph == 0) begin
        in_valid = 1'b1;
        in_null  = 2'b01;
      end
      step();
      in_valid = 1'b0;
    end
    for (int ph = 0; ph < G; ph++) begin
      checks++;
      if (spk !== exp_spk(12, 0, 2'b01, 1'b1, ph)) begin
        errors++; $display("[TB] FAIL null_ch0: ph=%0d got %b want %b", ph, spk, exp_spk(12, 0, 2'b01, 1'b1, ph));
      end
      step();
    end
    in_null = 2'b00;
  endtask

  task automatic test_idle();
    for (int ph = 0; ph < G; ph++) begin
      checks += 2;
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy: ph=%0d got %b want 0", ph, busy); end
      if (spk !== IDLE) begin errors++; $display("[TB] FAIL idle_spk: ph=%0d got %b want %b", ph, spk, IDLE); end
      step();
    end
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1;
    in_val   = {4'd4, 4'd2};
    step();
    in_valid = 1'b0;
    wait_phase(0);
    in_valid = 1'b1;
    in_val   = {4'd6, 4'd6};
    step();
    in_valid = 1'b0;
    wait_phase(6);
    checks++;
    if (spk !== exp_spk(2, 4, 2'b00, 1'b1, 6)) begin
      errors++; $display("[TB] FAIL mid_spk: got %b want %b", spk, exp_spk(2, 4, 2'b00, 1'b1, 6));
    end
    grst = 1'b1;
    step();
    checks += 4;
    if (spk !== IDLE) begin errors++; $display("[TB] FAIL mid_rst_spk: got %b want %b", spk, IDLE); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_busy: got %b want 0", busy); end
    if (gphase !== 4'd0) begin errors++; $display("[TB] FAIL mid_rst_phase: got %0d want 0", gphase); end
    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_ready: got %b want 0", in_ready); end
    grst = 1'b0;
    step();
    checks += 2;
    if (gphase !== 4'd0) begin errors++; $display("[TB] FAIL restart_phase: got %0d want 0", gphase); end
    if (gstart !== 1'b1) begin errors++; $display("[TB] FAIL restart_gstart: got %b want 1", gstart); end
    for (int k = 0; k < G + 2; k++) begin
      checks += 2;
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL pend_dropped: k=%0d got %b want 0", k, busy); end
      if (spk !== IDLE) begin errors++; $display("[TB] FAIL post_rst_spk: k=%0d got %b want %b", k, spk, IDLE); end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_replay_and_hold();
    test_truncate_null();
    test_idle();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
